// File: rtl/fpga_ram_arb.sv
// fpga_ram_arb: two-requester arbiter in front of a single-port RAM.
//
// After reset the RAM is cleared by a sweep (StInit) that writes zero to every
// address. Once the sweep finishes, InitDone goes high and the block moves to
// StRun. In StRun it grants one request per cycle and drives that request onto
// the RAM in the same cycle. A read returns its data on the issuing channel one
// cycle later.
//
// Arbitration when both requesters are valid:
//   FPGA_RAM_ARB_RR_EN defined   : round-robin (requester not granted last wins)
//   FPGA_RAM_ARB_RR_EN undefined : fixed priority, requester 0 wins
//
// Ports:
//   Clk, Reset             clock; synchronous active-high reset
//   ReqnValid/Ready/Write  request channel n handshake and direction
//   ReqnAddr/ReqnWData     request channel n payload
//   RspnValid/RspnRData    read response channel n (no backpressure, data 0 when idle)
//   RamAddr/RamDataIn/     single-port RAM interface (1-cycle read latency,
//   RamWriteEnable/        write-first)
//   RamDataOut
//   InitDone               high once the RAM clear sweep has completed
module fpga_ram_arb #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req0Valid,
  output logic                 Req0Ready,
  input  logic                 Req0Write,
  input  logic [ADDRWIDTH-1:0] Req0Addr,
  input  logic [DATAWIDTH-1:0] Req0WData,
  input  logic                 Req1Valid,
  output logic                 Req1Ready,
  input  logic                 Req1Write,
  input  logic [ADDRWIDTH-1:0] Req1Addr,
  input  logic [DATAWIDTH-1:0] Req1WData,
  output logic                 Rsp0Valid,
  output logic [DATAWIDTH-1:0] Rsp0RData,
  output logic                 Rsp1Valid,
  output logic [DATAWIDTH-1:0] Rsp1RData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut,
  output logic                 InitDone
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 rsp_id_q, rsp_id_d;
  logic                 gnt0, gnt1;
  logic                 run;

  // Reset masks all activity in the cycle it is high, not just the next one.
  assign run = (state_q == StRun) && !Reset;

`ifdef FPGA_RAM_ARB_RR_EN
  // Requester favoured on contention; flips only when a handshake happens.
  logic prio_q, prio_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (Req0Valid && Req1Valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = Req0Valid;
        gnt1 = Req1Valid;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign gnt0 = run && Req0Valid;
  assign gnt1 = run && Req1Valid && !Req0Valid;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_vld_d      = 1'b0;
    rsp_id_d       = rsp_id_q;
    RamWriteEnable = 1'b0;
    case (state_q)
      StInit: begin
        if (!Reset) begin
          RamWriteEnable = 1'b1;
          addr_d         = cnt_q;
          wdata_d        = '0;
          // Last address written: leave the sweep without wrapping the counter.
          if (&cnt_q) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (gnt0) begin
          addr_d         = Req0Addr;
          wdata_d        = Req0WData;
          RamWriteEnable = Req0Write;
          rsp_vld_d      = ~Req0Write;
          rsp_id_d       = 1'b0;
        end else if (gnt1) begin
          addr_d         = Req1Addr;
          wdata_d        = Req1WData;
          RamWriteEnable = Req1Write;
          rsp_vld_d      = ~Req1Write;
          rsp_id_d       = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // addr_d/wdata_d equal the held values whenever nothing new is driven.
  assign RamAddr   = addr_d;
  assign RamDataIn = wdata_d;

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;

  assign Rsp0Valid = rsp_vld_q && !rsp_id_q && !Reset;
  assign Rsp1Valid = rsp_vld_q && rsp_id_q && !Reset;
  assign Rsp0RData = Rsp0Valid ? RamDataOut : '0;
  assign Rsp1RData = Rsp1Valid ? RamDataOut : '0;

  assign InitDone = run;

endmodule
